ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// RamArbiter (module ram_arbiter)
//
// Purpose:
//   Shares one single-port word RAM between an instruction fetch port
//   (read-only) and a data port (read/write with byte enables). The two ports
//   are served one access at a time with round-robin arbitration. Every access
//   is followed by a short drain window. During that window the RAM's
//   lingering ready signal is ignored, so it is never mistaken for the
//   completion of the next access.
//
// Ports:
//   clk_i, rst_i            clock (rising edge) and synchronous active-high reset
//   i_req_i, i_addr_i       instruction read request and word address
//   i_ack_o, i_rdata_o      instruction completion pulse and registered read data
//   d_req_i, d_we_i         data request and direction (1 write, 0 read)
//   d_addr_i, d_wdata_i,    data word address, write data and byte enables
//   d_be_i
//   d_ack_o, d_rdata_o      data completion pulse and registered read data
//   ram_read_o, ram_write_o RAM strobes, held for the whole access
//   ram_addr_o, ram_wdata_o,
//   ram_be_o                RAM address, write data and byte enables
//   ram_ready_i,            RAM completion handshake and read data
//   ram_rdata_i
//   busy_o                  high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module ram_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ack_o,
  output logic [31:0]       i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  input  logic [3:0]        d_be_i,
  output logic              d_ack_o,
  output logic [31:0]       d_rdata_o,
  output logic              ram_read_o,
  output logic              ram_write_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  output logic [3:0]        ram_be_o,
  input  logic              ram_ready_i,
  input  logic [31:0]       ram_rdata_i,
  output logic              busy_o
);

  // The drain counter has to hold DRAIN_CYCLES itself. DRAIN_CYCLES must be at least 1.
  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_drainCnt;
  logic              r_lastGrantD;
  logic              r_winnerD;
  logic              r_read;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic              r_iAck;
  logic              r_dAck;
  logic [31:0]       r_iRdata;
  logic [31:0]       r_dRdata;

  logic w_anyReq;
  logic w_grantD;

  // Round-robin choice. A lone data request wins outright. When both ports
  // request, data wins only if instruction was the last one granted.
  assign w_anyReq = i_req_i | d_req_i;
  assign w_grantD = d_req_i & (~i_req_i | ~r_lastGrantD);

  // Main sequencer: IDLE samples requests and latches the winner's fields.
  // ACCESS holds the strobe until the RAM reports ready. DRAIN counts down
  // while ready and all requests are ignored. Reset parks the FSM in DRAIN,
  // so a RAM that was mid-access has time to drop ready before IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= DRAIN;
      r_drainCnt   <= DRAIN_LOAD;
      r_lastGrantD <= 1'b1;
      r_winnerD    <= 1'b0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_iAck       <= 1'b0;
      r_dAck       <= 1'b0;
      r_iRdata     <= '0;
      r_dRdata     <= '0;
    end else begin
      r_iAck <= 1'b0;
      r_dAck <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_state      <= ACCESS;
            r_winnerD    <= w_grantD;
            r_lastGrantD <= w_grantD;
            if (w_grantD) begin
              r_addr  <= d_addr_i;
              r_wdata <= d_wdata_i;
              r_be    <= d_be_i;
              r_read  <= ~d_we_i;
              r_write <= d_we_i;
            end else begin
              // Instruction fetches are always full-word reads.
              r_addr  <= i_addr_i;
              r_wdata <= '0;
              r_be    <= 4'hF;
              r_read  <= 1'b1;
              r_write <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (ram_ready_i) begin
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_state    <= DRAIN;
            r_drainCnt <= DRAIN_LOAD;
            if (r_winnerD) begin
              r_dAck <= 1'b1;
              // A write leaves the data port's last read value untouched.
              if (r_read) begin
                r_dRdata <= ram_rdata_i;
              end
            end else begin
              r_iAck   <= 1'b1;
              r_iRdata <= ram_rdata_i;
            end
          end
        end
        DRAIN: begin
          r_drainCnt <= r_drainCnt - CNT_ONE;
          if (r_drainCnt == CNT_ONE) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign i_ack_o     = r_iAck;
  assign i_rdata_o   = r_iRdata;
  assign d_ack_o     = r_dAck;
  assign d_rdata_o   = r_dRdata;
  assign ram_read_o  = r_read;
  assign ram_write_o = r_write;
  assign ram_addr_o  = r_addr;
  assign ram_wdata_o = r_wdata;
  assign ram_be_o    = r_be;
  assign busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// TbRamArbiter (module tb_ram_arbiter)
//
// Purpose:
//   Self-checking bench for ram_arbiter. It contains a behavioural RAM with
//   the documented ready timing, a table of single transactions, hand-written
//   corner sequences, and a randomized phase checked against a
//   transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

  localparam int ADDR_W = 15;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              i_req_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic              i_ack_o;
  logic [31:0]       i_rdata_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [31:0]       d_wdata_i;
  logic [3:0]        d_be_i;
  logic              d_ack_o;
  logic [31:0]       d_rdata_o;
  logic              ram_read_o;
  logic              ram_write_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [31:0]       ram_wdata_o;
  logic [3:0]        ram_be_o;
  logic              ram_ready_i;
  logic [31:0]       ram_rdata_i;
  logic              busy_o;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] expIRd;
  logic [31:0] expDRd;

  always #5 clk_i = ~clk_i;

  ram_arbiter #(.ADDR_W(ADDR_W), .DRAIN_CYCLES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_ack_o(i_ack_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
    .ram_read_o(ram_read_o), .ram_write_o(ram_write_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o),
    .ram_ready_i(ram_ready_i), .ram_rdata_i(ram_rdata_i), .busy_o(busy_o)
  );

  // Behavioural RAM. Ready rises on the second cycle of a held strobe and
  // stays up for two cycles after the strobe drops. Writes land on the edge
  // where the strobe and ready are both high.
  logic [31:0] ramMem [0:(1<<ADDR_W)-1];
  logic        rdyReg = 1'b0;
  logic        forceNotReady = 1'b0;
  int          onCnt = 0;
  int          offCnt = 0;

  assign ram_ready_i = rdyReg & ~forceNotReady;
  assign ram_rdata_i = ramMem[ram_addr_o];

  always @(posedge clk_i) begin
    if (ram_read_o || ram_write_o) begin
      if (onCnt < 2) onCnt <= onCnt + 1;
      offCnt <= 0;
      if (onCnt >= 1) rdyReg <= 1'b1;
    end else begin
      onCnt <= 0;
      if (rdyReg) begin
        if (offCnt >= 1) begin
          rdyReg <= 1'b0;
          offCnt <= 0;
        end else begin
          offCnt <= offCnt + 1;
        end
      end
    end
    if (ram_write_o && ram_ready_i) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be_o[b]) ramMem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end
    end
  end

  function automatic logic [31:0] initWord(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  typedef struct {
    logic              isD;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic [31:0]       expRdata;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reset for two edges, then release. Checks the reset values and the
  // two-cycle busy drain. Returns in the first IDLE cycle.
  task automatic doReset();
    rst_i = 1'b1;
    tick();
    checkOutput("rst i_ack", 32'(i_ack_o), 32'd0);
    checkOutput("rst d_ack", 32'(d_ack_o), 32'd0);
    checkOutput("rst i_rdata", i_rdata_o, 32'd0);
    checkOutput("rst d_rdata", d_rdata_o, 32'd0);
    checkOutput("rst ram_read", 32'(ram_read_o), 32'd0);
    checkOutput("rst ram_write", 32'(ram_write_o), 32'd0);
    checkOutput("rst ram_addr", 32'(ram_addr_o), 32'd0);
    checkOutput("rst ram_wdata", ram_wdata_o, 32'd0);
    checkOutput("rst ram_be", 32'(ram_be_o), 32'd0);
    checkOutput("rst busy", 32'(busy_o), 32'd1);
    tick();
    rst_i = 1'b0;
    expIRd = '0;
    expDRd = '0;
    checkOutput("post-rst busy c0", 32'(busy_o), 32'd1);
    tick();
    checkOutput("post-rst busy c1", 32'(busy_o), 32'd1);
    tick();
    checkOutput("post-rst busy c2", 32'(busy_o), 32'd0);
  endtask

  // One isolated transaction, started in an IDLE cycle T. Expects the strobe
  // at T+1..T+3, the ack at T+4 only, and returns in the IDLE cycle T+6.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic rd;
    logic strobe;
    rd = !(v.isD && v.we);
    checkOutput($sformatf("v%0d busy idle", idx), 32'(busy_o), 32'd0);
    if (v.isD) begin
      d_req_i = 1'b1; d_we_i = v.we; d_addr_i = v.addr; d_wdata_i = v.wdata; d_be_i = v.be;
    end else begin
      i_req_i = 1'b1; i_addr_i = v.addr;
      d_we_i = 1'b1; d_addr_i = 15'h1234; d_wdata_i = 32'h55AA_55AA; d_be_i = 4'b0101;
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k <= 5) begin
        strobe = (k <= 3);
        checkOutput($sformatf("v%0d k%0d ram_read", idx, k), 32'(ram_read_o), 32'(strobe && rd));
        checkOutput($sformatf("v%0d k%0d ram_write", idx, k), 32'(ram_write_o), 32'(strobe && !rd));
        if (strobe) begin
          checkOutput($sformatf("v%0d k%0d ram_addr", idx, k), 32'(ram_addr_o), 32'(v.addr));
          checkOutput($sformatf("v%0d k%0d ram_be", idx, k), 32'(ram_be_o), 32'(v.isD ? v.be : 4'hF));
          checkOutput($sformatf("v%0d k%0d ram_wdata", idx, k), ram_wdata_o, v.isD ? v.wdata : 32'd0);
        end
        if (k == 4 && rd) begin
          if (v.isD) expDRd = v.expRdata;
          else       expIRd = v.expRdata;
        end
        checkOutput($sformatf("v%0d k%0d i_ack", idx, k), 32'(i_ack_o), 32'(k == 4 && !v.isD));
        checkOutput($sformatf("v%0d k%0d d_ack", idx, k), 32'(d_ack_o), 32'(k == 4 && v.isD));
        checkOutput($sformatf("v%0d k%0d i_rdata", idx, k), i_rdata_o, expIRd);
        checkOutput($sformatf("v%0d k%0d d_rdata", idx, k), d_rdata_o, expDRd);
        if (k == 4) begin
          i_req_i = 1'b0;
          d_req_i = 1'b0;
        end
      end
    end
  endtask

  // Randomized traffic from both ports, checked against a transaction-level
  // model. That model grants in any cycle at or after the point where the
  // arbiter is free, acks four cycles later, and becomes free again six cycles
  // after the grant.
  task automatic runRandom(input int nCycles);
    logic [31:0] refMem [16];
    int          freeAt;
    logic        lastD;
    logic        txnOpen;
    int          g;
    logic        gD;
    logic        gWe;
    logic [ADDR_W-1:0] gAddr;
    logic [31:0] gWdata;
    logic [3:0]  gBe;
    logic        active;
    int          idx;
    for (int i = 0; i < 16; i++) refMem[i] = initWord(32'h100 + i);
    freeAt = 0; lastD = 1'b1; txnOpen = 1'b0; g = 0;
    gD = 1'b0; gWe = 1'b0; gAddr = '0; gWdata = '0; gBe = '0;
    for (int c = 0; c < nCycles; c++) begin
      active = txnOpen && (c > g) && (c <= g + 3);
      checkOutput($sformatf("rnd c%0d ram_read", c), 32'(ram_read_o), 32'(active && !gWe));
      checkOutput($sformatf("rnd c%0d ram_write", c), 32'(ram_write_o), 32'(active && gWe));
      if (active) checkOutput($sformatf("rnd c%0d ram_addr", c), 32'(ram_addr_o), 32'(gAddr));
      if (txnOpen && c == g + 4) begin
        idx = int'(gAddr) - 32'h100;
        if (gWe) begin
          for (int b = 0; b < 4; b++) if (gBe[b]) refMem[idx][8*b +: 8] = gWdata[8*b +: 8];
        end else if (gD) begin
          expDRd = refMem[idx];
        end else begin
          expIRd = refMem[idx];
        end
      end
      checkOutput($sformatf("rnd c%0d i_ack", c), 32'(i_ack_o), 32'(txnOpen && c == g + 4 && !gD));
      checkOutput($sformatf("rnd c%0d d_ack", c), 32'(d_ack_o), 32'(txnOpen && c == g + 4 && gD));
      checkOutput($sformatf("rnd c%0d i_rdata", c), i_rdata_o, expIRd);
      checkOutput($sformatf("rnd c%0d d_rdata", c), d_rdata_o, expDRd);
      if (txnOpen && c == g + 4) begin
        if (gD) d_req_i = 1'b0;
        else    i_req_i = 1'b0;
        txnOpen = 1'b0;
      end
      if (!i_req_i && $urandom_range(2) == 0) begin
        i_req_i = 1'b1;
        i_addr_i = 15'(32'h100 + $urandom_range(15));
      end
      if (!d_req_i && $urandom_range(2) == 0) begin
        d_req_i = 1'b1;
        d_we_i = 1'($urandom_range(1));
        d_addr_i = 15'(32'h100 + $urandom_range(15));
        d_wdata_i = $urandom;
        d_be_i = 4'($urandom_range(15));
      end
      if (c >= freeAt && (i_req_i || d_req_i)) begin
        gD = (i_req_i && d_req_i) ? !lastD : d_req_i;
        lastD = gD;
        g = c;
        freeAt = c + 6;
        txnOpen = 1'b1;
        gWe = gD && d_we_i;
        gAddr = gD ? d_addr_i : i_addr_i;
        gWdata = d_wdata_i;
        gBe = d_be_i;
      end
      tick();
    end
    i_req_i = 1'b0;
    d_req_i = 1'b0;
    for (int k = 0; k < 8; k++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_i = 1'b0; i_req_i = 1'b0; i_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
    expIRd = '0; expDRd = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) ramMem[i] <= initWord(i);
    ramMem[16] <= 32'hDEAD_BEEF;

    vecs[0]  = '{1'b0, 1'b0, 15'h0010, 32'h0,         4'hF,    32'hDEAD_BEEF};
    vecs[1]  = '{1'b1, 1'b1, 15'h0004, 32'h1234_5678, 4'b0011, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 15'h0004, 32'h0,         4'hF,    32'hA500_5678};
    vecs[3]  = '{1'b0, 1'b0, 15'h0004, 32'h0,         4'hF,    32'hA500_5678};
    vecs[4]  = '{1'b1, 1'b1, 15'h0020, 32'hCAFE_F00D, 4'hF,    32'h0};
    vecs[5]  = '{1'b1, 1'b0, 15'h0020, 32'h0,         4'hF,    32'hCAFE_F00D};
    vecs[6]  = '{1'b1, 1'b1, 15'h0020, 32'h1122_3344, 4'b1000, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 15'h0020, 32'h0,         4'hF,    32'h11FE_F00D};
    vecs[8]  = '{1'b1, 1'b0, 15'h7FFF, 32'h0,         4'hF,    32'hA500_7FFF};
    vecs[9]  = '{1'b1, 1'b1, 15'h7FFF, 32'hFFFF_FFFF, 4'b0000, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 15'h7FFF, 32'h0,         4'hF,    32'hA500_7FFF};

    doReset();
    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

    // A request held past its ack is a new request. The lingering ready must
    // not produce a second ack, and the next strobe may start only at T+7.
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 15'h0010; d_be_i = 4'hF;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checkOutput($sformatf("hold k%0d ram_read", k), 32'(ram_read_o),
                  32'((k >= 1 && k <= 3) || (k >= 7 && k <= 9)));
      checkOutput($sformatf("hold k%0d d_ack", k), 32'(d_ack_o), 32'(k == 4 || k == 10));
      if (k == 4) expDRd = 32'hDEAD_BEEF;
      checkOutput($sformatf("hold k%0d d_rdata", k), d_rdata_o, expDRd);
      if (k == 10) d_req_i = 1'b0;
    end
    checkOutput("hold idle busy", 32'(busy_o), 32'd0);

    // Reset in the middle of an access abandons it without an ack.
    i_req_i = 1'b1; i_addr_i = 15'h0020;
    tick();
    checkOutput("abort k1 ram_read", 32'(ram_read_o), 32'd1);
    tick();
    checkOutput("abort k2 ram_read", 32'(ram_read_o), 32'd1);
    rst_i = 1'b1; i_req_i = 1'b0;
    tick();
    rst_i = 1'b0; expIRd = '0; expDRd = '0;
    checkOutput("abort k3 ram_read", 32'(ram_read_o), 32'd0);
    checkOutput("abort k3 ram_addr", 32'(ram_addr_o), 32'd0);
    checkOutput("abort k3 i_ack", 32'(i_ack_o), 32'd0);
    checkOutput("abort k3 i_rdata", i_rdata_o, 32'd0);
    checkOutput("abort k3 busy", 32'(busy_o), 32'd1);
    tick();
    checkOutput("abort k4 i_ack", 32'(i_ack_o), 32'd0);
    checkOutput("abort k4 busy", 32'(busy_o), 32'd1);
    tick();
    checkOutput("abort k5 i_ack", 32'(i_ack_o), 32'd0);
    applyStimulus(vecs[0], 100);

    // Ready withheld for twenty cycles: the access must simply wait.
    forceNotReady = 1'b1;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 15'h0004; d_be_i = 4'hF;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checkOutput($sformatf("stall k%0d ram_read", k), 32'(ram_read_o), 32'd1);
      checkOutput($sformatf("stall k%0d ram_addr", k), 32'(ram_addr_o), 32'h4);
      checkOutput($sformatf("stall k%0d d_ack", k), 32'(d_ack_o), 32'd0);
    end
    forceNotReady = 1'b0;
    tick();
    checkOutput("stall k21 d_ack", 32'(d_ack_o), 32'd1);
    checkOutput("stall k21 d_rdata", d_rdata_o, 32'hA500_5678);
    checkOutput("stall k21 ram_read", 32'(ram_read_o), 32'd0);
    expDRd = 32'hA500_5678;
    d_req_i = 1'b0;
    tick();
    checkOutput("stall k22 d_ack", 32'(d_ack_o), 32'd0);
    tick();
    checkOutput("stall idle busy", 32'(busy_o), 32'd0);

    // Both ports request continuously from reset. Grants alternate, starting
    // with instruction, and the acks land six cycles apart.
    i_req_i = 1'b1; i_addr_i = 15'h0010;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 15'h0004; d_be_i = 4'hF;
    doReset();
    for (int k = 1; k <= 35; k++) begin
      tick();
      checkOutput($sformatf("rr k%0d i_ack", k), 32'(i_ack_o), 32'(k == 4 || k == 16 || k == 28));
      checkOutput($sformatf("rr k%0d d_ack", k), 32'(d_ack_o), 32'(k == 10 || k == 22 || k == 34));
      if (k == 4)  expIRd = 32'hDEAD_BEEF;
      if (k == 10) expDRd = 32'hA500_5678;
      checkOutput($sformatf("rr k%0d i_rdata", k), i_rdata_o, expIRd);
      checkOutput($sformatf("rr k%0d d_rdata", k), d_rdata_o, expDRd);
    end
    i_req_i = 1'b0; d_req_i = 1'b0;
    tick();
    checkOutput("rr idle busy", 32'(busy_o), 32'd0);

    doReset();
    runRandom(1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
